// File: rtl/prf_read_arbiter_if.sv
// Request/grant and bank read-port bundle between PRF read requestors, the
// read arbiter and the banked PRF array.
interface prf_read_arbiter_if #(
  parameter int PR_COUNT            = 128,
  parameter int PRF_BANK_COUNT      = 4,
  parameter int PRF_READ_PORT_COUNT = 2,
  parameter int PRF_RR_COUNT        = 11
);
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  localparam int SLOTS              = PRF_BANK_COUNT * PRF_READ_PORT_COUNT;

  logic [PRF_RR_COUNT-1:0]                    req_valid_by_rr;
  logic [PRF_RR_COUNT*LOG_PR_COUNT-1:0]       req_PR_by_rr;
  logic [PRF_RR_COUNT-1:0]                    req_ready_by_rr;
  logic                                       stall;
  logic [SLOTS-1:0]                           read_valid_by_bank_port;
  logic [SLOTS*ROW_W-1:0]                     read_index_by_bank_port;
  logic [PRF_RR_COUNT-1:0]                    resp_valid_by_rr;
  logic [PRF_RR_COUNT*LOG_PRF_BANK_COUNT-1:0] resp_bank_by_rr;
  logic [PRF_RR_COUNT-1:0]                    resp_port_by_rr;

  modport master (
    output req_valid_by_rr, req_PR_by_rr, stall,
    input  req_ready_by_rr, read_valid_by_bank_port, read_index_by_bank_port,
           resp_valid_by_rr, resp_bank_by_rr, resp_port_by_rr
  );

  modport slave (
    input  req_valid_by_rr, req_PR_by_rr, stall,
    output req_ready_by_rr, read_valid_by_bank_port, read_index_by_bank_port,
           resp_valid_by_rr, resp_bank_by_rr, resp_port_by_rr
  );
endinterface

// File: rtl/prf_read_arbiter.sv
// Banked PRF read-port arbiter: per-bank round-robin, two ports per bank, grants
// returned combinationally. Optional macro PRF_ARB_DUP_MERGE_EN merges same-PR reads.
module prf_read_arbiter #(
  parameter int PR_COUNT            = 128,
  parameter int PRF_BANK_COUNT      = 4,
  parameter int PRF_READ_PORT_COUNT = 2,
  parameter int PRF_RR_COUNT        = 11
) (
  input  logic              CLK,
  input  logic              rst,
  prf_read_arbiter_if.slave arb
);
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int LOG_PRF_RR_COUNT   = $clog2(PRF_RR_COUNT);
  localparam int ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  localparam int SLOTS              = PRF_BANK_COUNT * PRF_READ_PORT_COUNT;

  logic [LOG_PRF_RR_COUNT-1:0] r_ptr [PRF_BANK_COUNT];

  logic [PRF_RR_COUNT-1:0]        w_grant_bank    [PRF_BANK_COUNT];
  logic [PRF_RR_COUNT-1:0]        w_port_bank     [PRF_BANK_COUNT];
  logic [PRF_READ_PORT_COUNT-1:0] w_pvalid_bank   [PRF_BANK_COUNT];
  logic [ROW_W-1:0]               w_prow_bank     [PRF_BANK_COUNT][PRF_READ_PORT_COUNT];
  logic                           w_any_bank      [PRF_BANK_COUNT];
  logic [LOG_PRF_RR_COUNT-1:0]    w_next_ptr_bank [PRF_BANK_COUNT];

  logic [PRF_RR_COUNT-1:0] w_grant_all;
  logic [PRF_RR_COUNT-1:0] w_port_all;

  logic [SLOTS-1:0]                           r_read_valid;
  logic [SLOTS*ROW_W-1:0]                     r_read_index;
  logic [PRF_RR_COUNT-1:0]                    r_resp_valid;
  logic [PRF_RR_COUNT*LOG_PRF_BANK_COUNT-1:0] r_resp_bank;
  logic [PRF_RR_COUNT-1:0]                    r_resp_port;

  for (genvar gi = 0; gi < PRF_BANK_COUNT; gi++) begin : g_bank
    logic [PRF_RR_COUNT-1:0]     w_grant;
    logic [PRF_RR_COUNT-1:0]     w_port;
    logic                        w_p0_found;
    logic                        w_p1_found;
    logic [LOG_PR_COUNT-1:0]     w_p0_pr;
    logic [LOG_PR_COUNT-1:0]     w_p1_pr;
    logic [LOG_PRF_RR_COUNT-1:0] w_last;
    logic [LOG_PR_COUNT-1:0]     w_pr;
    int                          w_idx;

    // Scan requestors starting at this bank's pointer, wrapping explicitly
    // because the requestor count need not be a power of two.
    always_comb begin
      w_grant    = '0;
      w_port     = '0;
      w_p0_found = 1'b0;
      w_p1_found = 1'b0;
      w_p0_pr    = '0;
      w_p1_pr    = '0;
      w_last     = '0;
      w_pr       = '0;
      w_idx      = 0;
      for (int k = 0; k < PRF_RR_COUNT; k++) begin
        w_idx = int'(r_ptr[gi]) + k;
        if (w_idx >= PRF_RR_COUNT) w_idx = w_idx - PRF_RR_COUNT;
        w_pr = arb.req_PR_by_rr[w_idx*LOG_PR_COUNT +: LOG_PR_COUNT];
        if (arb.req_valid_by_rr[w_idx] &&
            (w_pr[LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(gi))) begin
          if (!w_p0_found) begin
            w_p0_found     = 1'b1;
            w_p0_pr        = w_pr;
            w_grant[w_idx] = 1'b1;
            w_last         = LOG_PRF_RR_COUNT'(w_idx);
          end
`ifdef PRF_ARB_DUP_MERGE_EN
          else if (w_pr == w_p0_pr) begin
            w_grant[w_idx] = 1'b1;
            w_last         = LOG_PRF_RR_COUNT'(w_idx);
          end
          else if (!w_p1_found) begin
            w_p1_found     = 1'b1;
            w_p1_pr        = w_pr;
            w_grant[w_idx] = 1'b1;
            w_port[w_idx]  = 1'b1;
            w_last         = LOG_PRF_RR_COUNT'(w_idx);
          end
          else if (w_pr == w_p1_pr) begin
            w_grant[w_idx] = 1'b1;
            w_port[w_idx]  = 1'b1;
            w_last         = LOG_PRF_RR_COUNT'(w_idx);
          end
`else
          else if (!w_p1_found) begin
            w_p1_found     = 1'b1;
            w_p1_pr        = w_pr;
            w_grant[w_idx] = 1'b1;
            w_port[w_idx]  = 1'b1;
            w_last         = LOG_PRF_RR_COUNT'(w_idx);
          end
`endif
        end
      end
    end

    assign w_grant_bank[gi]     = w_grant;
    assign w_port_bank[gi]      = w_port;
    assign w_pvalid_bank[gi]    = {w_p1_found, w_p0_found};
    assign w_prow_bank[gi][0]   = w_p0_pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
    assign w_prow_bank[gi][1]   = w_p1_pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
    assign w_any_bank[gi]       = |w_grant;
    assign w_next_ptr_bank[gi]  = (int'(w_last) == PRF_RR_COUNT - 1) ? '0 : w_last + 1'b1;
  end

  // Each requestor belongs to exactly one bank, so the per-bank masks are disjoint.
  always_comb begin
    w_grant_all = '0;
    w_port_all  = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_grant_all = w_grant_all | w_grant_bank[b];
      w_port_all  = w_port_all  | w_port_bank[b];
    end
  end

  assign arb.req_ready_by_rr = (arb.stall || rst) ? '0 : w_grant_all;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_read_valid <= '0;
      r_read_index <= '0;
      r_resp_valid <= '0;
      r_resp_bank  <= '0;
      r_resp_port  <= '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) r_ptr[b] <= '0;
    end else if (!arb.stall) begin
      r_resp_valid <= w_grant_all;
      r_resp_port  <= w_port_all;
      for (int r = 0; r < PRF_RR_COUNT; r++) begin
        r_resp_bank[r*LOG_PRF_BANK_COUNT +: LOG_PRF_BANK_COUNT] <= w_grant_all[r]
            ? arb.req_PR_by_rr[r*LOG_PR_COUNT +: LOG_PRF_BANK_COUNT] : '0;
      end
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (w_any_bank[b]) r_ptr[b] <= w_next_ptr_bank[b];
        for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
          r_read_valid[b*PRF_READ_PORT_COUNT + p] <= w_pvalid_bank[b][p];
          r_read_index[(b*PRF_READ_PORT_COUNT + p)*ROW_W +: ROW_W] <= w_prow_bank[b][p];
        end
      end
    end
  end

  assign arb.read_valid_by_bank_port = r_read_valid;
  assign arb.read_index_by_bank_port = r_read_index;
  assign arb.resp_valid_by_rr        = r_resp_valid;
  assign arb.resp_bank_by_rr         = r_resp_bank;
  assign arb.resp_port_by_rr         = r_resp_port;
endmodule

// File: tb/tb_prf_read_arbiter.sv
// Bench for prf_read_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-style round-robin reference model.
module tb_prf_read_arbiter;
  localparam int PR_COUNT = 128;
  localparam int NB       = 4;
  localparam int NP       = 2;
  localparam int NRR      = 11;
  localparam int LPR      = 7;
  localparam int LB       = 2;
  localparam int ROW      = 5;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  prf_read_arbiter_if #(.PR_COUNT(PR_COUNT), .PRF_BANK_COUNT(NB),
                        .PRF_READ_PORT_COUNT(NP), .PRF_RR_COUNT(NRR)) bus ();

  prf_read_arbiter #(.PR_COUNT(PR_COUNT), .PRF_BANK_COUNT(NB),
                     .PRF_READ_PORT_COUNT(NP), .PRF_RR_COUNT(NRR)) dut (
    .CLK (CLK),
    .rst (rst),
    .arb (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus as seen by the requestors
  int s_valid [NRR];
  int s_pr    [NRR];
  int s_stall;

  // Reference model state
  int                m_ptr      [NB];
  int                m_nptr     [NB];
  int                m_port_pr  [NB][NP];
  int                m_port_cnt [NB];
  logic [NRR-1:0]    m_grant;
  logic [NRR-1:0]    m_port;
  logic [NRR-1:0]    exp_ready;
  logic [NRR-1:0]    obs_ready;
  logic [NB*NP-1:0]     e_rv;
  logic [NB*NP*ROW-1:0] e_ri;
  logic [NRR-1:0]       e_sv;
  logic [NRR*LB-1:0]    e_sb;
  logic [NRR-1:0]       e_sp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NRR; r++) begin
      bus.req_valid_by_rr[r] = (s_valid[r] != 0);
      bus.req_PR_by_rr[r*LPR +: LPR] = LPR'(s_pr[r]);
    end
    bus.stall = (s_stall != 0);
  endtask

  // Each bank walks its requestors in rotated order and hands out up to two
  // ports; a duplicate PR can share a port when merging is enabled.
  task automatic model_arb();
    m_grant = '0;
    m_port  = '0;
    for (int b = 0; b < NB; b++) begin
      int order[$];
      m_port_cnt[b] = 0;
      m_nptr[b]     = m_ptr[b];
      for (int k = 0; k < NRR; k++) order.push_back((m_ptr[b] + k) % NRR);
      while (order.size() > 0) begin
        int r;
        int hit;
        r   = order.pop_front();
        hit = -1;
        if (s_valid[r] != 0 && (s_pr[r] % NB) == b) begin
`ifdef PRF_ARB_DUP_MERGE_EN
          for (int p = 0; p < m_port_cnt[b]; p++)
            if (m_port_pr[b][p] == s_pr[r]) hit = p;
`endif
          if (hit < 0 && m_port_cnt[b] < NP) begin
            hit = m_port_cnt[b];
            m_port_pr[b][hit] = s_pr[r];
            m_port_cnt[b]++;
          end
          if (hit >= 0) begin
            m_grant[r] = 1'b1;
            m_port[r]  = (hit == 1);
            m_nptr[b]  = (r + 1) % NRR;
          end
        end
      end
    end
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic cycle(input string tag);
    drive();
    #1;
    model_arb();
    exp_ready = (rst || s_stall != 0) ? '0 : m_grant;
    obs_ready = bus.req_ready_by_rr;
    chk({tag, ":ready"}, 64'(obs_ready), 64'(exp_ready));
    if (rst) begin
      e_rv = '0; e_ri = '0; e_sv = '0; e_sb = '0; e_sp = '0;
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    end else if (s_stall == 0) begin
      e_sv = m_grant;
      e_sp = m_port;
      for (int r = 0; r < NRR; r++)
        e_sb[r*LB +: LB] = m_grant[r] ? LB'(s_pr[r] % NB) : '0;
      for (int b = 0; b < NB; b++) begin
        m_ptr[b] = m_nptr[b];
        for (int p = 0; p < NP; p++) begin
          e_rv[b*NP + p] = (p < m_port_cnt[b]);
          e_ri[(b*NP + p)*ROW +: ROW] = (p < m_port_cnt[b]) ? ROW'(m_port_pr[b][p] / NB) : '0;
        end
      end
    end
    @(posedge CLK);
    #1;
    chk({tag, ":read_valid"}, 64'(bus.read_valid_by_bank_port), 64'(e_rv));
    chk({tag, ":read_index"}, 64'(bus.read_index_by_bank_port), 64'(e_ri));
    chk({tag, ":resp_valid"}, 64'(bus.resp_valid_by_rr), 64'(e_sv));
    chk({tag, ":resp_bank"},  64'(bus.resp_bank_by_rr),  64'(e_sb));
    chk({tag, ":resp_port"},  64'(bus.resp_port_by_rr),  64'(e_sp));
    @(negedge CLK);
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < NRR; r++) begin
      s_valid[r] = 0;
      s_pr[r]    = 0;
    end
  endtask

  logic [NRR-1:0] hold_sv;
  int pa;
  int pb;

  initial begin
    rst = 1'b1;
    s_stall = 0;
    clear_reqs();
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    drive();
    @(negedge CLK);
    cycle("reset0");
    cycle("reset1");
    chk("reset:resp_valid", 64'(bus.resp_valid_by_rr), 64'd0);
    chk("reset:read_valid", 64'(bus.read_valid_by_bank_port), 64'd0);
    rst = 1'b0;

    // Two requestors on bank 1 share the bank's two ports
    s_valid[0] = 1; s_pr[0] = 5;
    s_valid[1] = 1; s_pr[1] = 9;
    cycle("bank1_pair");
    chk("bank1_pair:ready_const", 64'(obs_ready), 64'h3);
    chk("bank1_pair:rv_const", 64'(bus.read_valid_by_bank_port), 64'h0C);
    chk("bank1_pair:ri_const", 64'(bus.read_index_by_bank_port), 64'h10400);
    chk("bank1_pair:bank_const", 64'(bus.resp_bank_by_rr), 64'h5);
    chk("bank1_pair:port_const", 64'(bus.resp_port_by_rr), 64'h2);
    chk("bank1_pair:ptr1", 64'(dut.r_ptr[1]), 64'd2);
    clear_reqs();

    // Move ptr[0] to 4, then exercise the wrap
    s_valid[3] = 1; s_pr[3] = 0;
    cycle("ptr0_setup");
    chk("ptr0_setup:ptr0", 64'(dut.r_ptr[0]), 64'd4);
    clear_reqs();
    s_valid[0] = 1; s_pr[0] = 4;
    s_valid[3] = 1; s_pr[3] = 8;
    s_valid[7] = 1; s_pr[7] = 12;
    cycle("wrap");
    chk("wrap:ready_const", 64'(obs_ready), 64'h081);
    chk("wrap:port_const", 64'(bus.resp_port_by_rr), 64'h001);
    chk("wrap:ptr0", 64'(dut.r_ptr[0]), 64'd1);
    s_valid[0] = 0; s_valid[7] = 0;
    cycle("wrap_held");
    chk("wrap_held:ready_const", 64'(obs_ready), 64'h008);
    clear_reqs();

    // Everyone on bank 2: pairs rotate and wrap without starvation
    for (int r = 0; r < NRR; r++) begin s_valid[r] = 1; s_pr[r] = 2 + 4*r; end
    for (int i = 0; i < 6; i++) begin
      pa = (2*i) % NRR;
      pb = (2*i + 1) % NRR;
      cycle($sformatf("fair%0d", i));
      chk($sformatf("fair%0d:pair", i), 64'(obs_ready), 64'((1 << pa) | (1 << pb)));
    end
    clear_reqs();

    // Stall freezes everything; grant lands once it drops
    s_valid[5] = 1; s_pr[5] = 1;
    hold_sv = bus.resp_valid_by_rr;
    s_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("stall%0d", i));
      chk($sformatf("stall%0d:hold", i), 64'(bus.resp_valid_by_rr), 64'(hold_sv));
    end
    s_stall = 0;
    cycle("unstall");
    chk("unstall:ready_const", 64'(obs_ready), 64'h020);
    clear_reqs();

    // Mid-stream reset restarts arbitration from requestor 0
    for (int r = 0; r < NRR; r++) begin s_valid[r] = 1; s_pr[r] = 3 + 4*r; end
    cycle("pre_rst0");
    cycle("pre_rst1");
    rst = 1'b1;
    cycle("mid_rst");
    chk("mid_rst:resp_valid", 64'(bus.resp_valid_by_rr), 64'd0);
    chk("mid_rst:ptr3", 64'(dut.r_ptr[3]), 64'd0);
    rst = 1'b0;
    cycle("post_rst");
    chk("post_rst:ready_const", 64'(obs_ready), 64'h003);
    clear_reqs();

    // Duplicate PRs in bank 0
    s_valid[2] = 1; s_pr[2] = 8;
    s_valid[4] = 1; s_pr[4] = 8;
    s_valid[6] = 1; s_pr[6] = 12;
    cycle("dup");
`ifdef PRF_ARB_DUP_MERGE_EN
    chk("dup:ready_const", 64'(obs_ready), 64'h054);
    chk("dup:port_const", 64'(bus.resp_port_by_rr), 64'h040);
    chk("dup:ri_bank0", 64'(bus.read_index_by_bank_port[9:0]), 64'h062);
`else
    chk("dup:ready_const", 64'(obs_ready), 64'h014);
    chk("dup:port_const", 64'(bus.resp_port_by_rr), 64'h010);
`endif
    clear_reqs();

    // Random traffic; ungranted requests stay put
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NRR; r++) begin
        if (exp_ready[r] || s_valid[r] == 0) begin
          s_valid[r] = ($urandom_range(0, 2) != 0) ? 1 : 0;
          s_pr[r]    = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15)
                                                    : $urandom_range(0, PR_COUNT - 1);
        end
      end
      s_stall = ($urandom_range(0, 7) == 0) ? 1 : 0;
      rst     = ($urandom_range(0, 63) == 0);
      cycle($sformatf("rand%0d", i));
      for (int b = 0; b < NB; b++)
        chk($sformatf("rand%0d:ptr%0d", i, b), 64'(dut.r_ptr[b]), 64'(m_ptr[b]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prf_read_arbiter.md
Name: prf_read_arbiter

Overview:
- Arbitrates the PRF_RR_COUNT physical-register-file read requestors onto the PRF_BANK_COUNT x PRF_READ_PORT_COUNT bank read ports.
- Bank selected by PR low bits; each bank has its own round-robin priority pointer.
- Grants are returned combinationally as ready; bank read addresses and requestor-to-port steering are registered one cycle later.
- Sits between issue-queue/operand-collector read requestors and the banked PRF array.

Parameters:
- PR_COUNT, 128, physical registers; LOG_PR_COUNT = $clog2(PR_COUNT).
- PRF_BANK_COUNT, 4, banks (power of 2); LOG_PRF_BANK_COUNT = $clog2.
- PRF_READ_PORT_COUNT, 2, read ports per bank; fixed at 2.
- PRF_RR_COUNT, 11, read requestors; LOG_PRF_RR_COUNT = $clog2(PRF_RR_COUNT).

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_by_rr  in  PRF_RR_COUNT  request valid per requestor.
- req_PR_by_rr  in  PRF_RR_COUNT*LOG_PR_COUNT  requested PR, flattened, requestor r at [r*LOG_PR_COUNT +: LOG_PR_COUNT].
- req_ready_by_rr  out  PRF_RR_COUNT  combinational grant; the request is consumed on valid&ready.
- stall  in  1  downstream PRF stall; freezes the arbiter.
- read_valid_by_bank_port  out  PRF_BANK_COUNT*2  registered port enable, index b*2+p.
- read_index_by_bank_port  out  PRF_BANK_COUNT*2*(LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  registered in-bank row (PR >> LOG_PRF_BANK_COUNT).
- resp_valid_by_rr  out  PRF_RR_COUNT  registered; requestor's data appears on the PRF output next cycle.
- resp_bank_by_rr  out  PRF_RR_COUNT*LOG_PRF_BANK_COUNT  registered bank steering.
- resp_port_by_rr  out  PRF_RR_COUNT  registered port steering (0/1).

Behaviour:
- Bank of a request = PR[LOG_PRF_BANK_COUNT-1:0].
- Each bank keeps ptr[b] (LOG_PRF_RR_COUNT bits), reset 0.
- Port 0 of bank b goes to the first valid requestor targeting b, scanning r = ptr[b], ptr[b]+1, ... modulo PRF_RR_COUNT. The wrap after index PRF_RR_COUNT-1 returns to 0; non-power-of-2 counts wrap explicitly.
- Port 1 of bank b goes to the next such requestor after the port 0 winner in the same scan.
- Up to 2 grants per bank and 8 per cycle. A requestor is granted at most once per cycle.
- ptr[b] update when not stalled: set to (last granted requestor in bank b + 1) mod PRF_RR_COUNT if bank b granted at least one request. Otherwise ptr[b] holds.
- req_ready is combinational from the current inputs and ptr. There is no ready-to-valid path.
- Ungranted requestors keep valid and PR stable. The arbiter does not buffer requests.
- Output registers load on every non-stalled cycle. Latency from grant to read_* and resp_* is exactly 1 cycle.
- Non-granted ports and requestors load 0. Index and steering fields are 0 when the corresponding valid is 0.
- stall=1: all req_ready=0; output registers and ptrs hold their values.
- Reset, including mid-stream: all outputs 0, all ptr 0. Reset overrides stall. The first grant can appear in the cycle after rst deasserts.
- With 1 requestor on a bank: port 0 is used, port 1 idle. With 0 requestors: both ports idle.
- Two requestors with the same PR consume two ports; merging is handled by the optional feature.

Optional Feature:
- Macro PRF_ARB_DUP_MERGE_EN.
- When defined, a requestor whose PR equals the PR already granted port 0 or port 1 of its bank this cycle is also granted. It is given resp_port equal to that port and uses no new port.
- Port 1 then goes to the next requestor in scan order with a distinct PR.
- Merged requestors count as granted for the ptr update.
- When not defined, every grant uses its own port.

Test Plan:
- Reset then rr0 and rr1 valid with PR 5 and 9 (both bank 1): both ready the same cycle. Next cycle: bank1 p0 index 1 / p1 index 2, resp_bank=1, resp_port 0/1. ptr[1] becomes 2.
- rr0, rr3, rr7 all valid to bank 0 with ptr[0]=4: rr7 gets p0, rr0 gets p1 via wrap, rr3 gets no grant. ptr[0] becomes 1. Hold rr3 valid: granted next cycle.
- All 11 requestors valid to bank 2 for 6 cycles: grant pairs (0,1),(2,3),(4,5),(6,7),(8,9),(10,0). No requestor starves.
- stall=1 for 3 cycles with requests pending: req_ready=0; read_* and resp_* and ptr unchanged. The grant occurs on the first cycle after stall drops.
- Assert rst during traffic: the next cycle shows all outputs 0 and the ptrs reset, so arbitration restarts from requestor 0.
- PRF_ARB_DUP_MERGE_EN: rr2, rr4, rr6 request PR 8, 8, 12 in bank 0. All three are ready. rr2 and rr4 get resp_port 0 (index 2); rr6 gets port 1 (index 3). Without the macro, rr6 receives no grant.
